fl_vframer: RTL and testbench
=============================

Name: fl_vframer

Overview:
- Upstream framing stage for the floating-point vector adder's x and y input streams. One instance per operand.
- Takes an unframed element stream plus a per-vector length command. Emits the same elements with an end-of-vector flag on the last element of each vector.
- Registered output, full throughput, standard valid/ready handshake on every interface.

Parameters:
- DATA_WIDTH, 32, element width in bits (raw IEEE-754 single by default; the block never interprets the value).
- LEN_WIDTH, 16, width of the vector-length command and of the vector counter.

Ports:
- clk, input, 1, the block's only clock.
- rst, input, 1, synchronous active-high reset.
- cfg_len, input, LEN_WIDTH, element count of the next vector.
- cfg_valid, input, 1, length command valid.
- cfg_ready, output, 1, block can accept a length command.
- in_data, input, DATA_WIDTH, incoming element.
- in_valid, input, 1, incoming element valid.
- in_ready, output, 1, element accepted this cycle when in_valid is also high.
- out_data, output, DATA_WIDTH, framed element.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts.
- out_end, output, 1, out_data is the last element of its vector.
- busy, output, 1, a vector is in progress or an output beat is pending.
- cfg_err, output, 1, single-cycle pulse: zero-length command rejected.
- vec_count, output, LEN_WIDTH, number of completed vectors delivered downstream.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE; the element counter clears.
  - Outputs: out_valid=0, out_data=0, out_end=0, cfg_err=0, vec_count=0.
  - A reset mid-vector discards the partial vector and any held output beat. No out_end is produced for it.
- State IDLE:
  - cfg_ready=1, in_ready=0.
  - On cfg_valid and cfg_len!=0: latch cfg_len, clear the element counter, go to STREAM.
  - On cfg_valid and cfg_len==0: the command is consumed, cfg_err pulses high for exactly one cycle, state stays IDLE.
- State STREAM:
  - cfg_ready=0.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready; no skid buffer.
  - On an input handshake (in_valid && in_ready):
    - out_data <= in_data, out_valid <= 1.
    - out_end <= (counter == len-1), then the counter increments.
    - If out_end is being set, go to IDLE.
- Output register:
  - Input-to-output latency is 1 cycle.
  - If out_valid && out_ready with no new input accepted, out_valid <= 0 and out_end <= 0.
  - out_data and out_end stay stable while out_valid && !out_ready.
- Throughput and gaps:
  - One element per cycle when out_ready is held high.
  - Minimum one-cycle bubble between vectors, because the cfg handshake only happens in IDLE.
  - A cfg command may be accepted in IDLE while the previous vector's last beat is still held in the output register.
- Counters and widths:
  - The element counter and latched length are LEN_WIDTH bits. Maximum vector length is 2^LEN_WIDTH - 1.
  - vec_count increments on out_valid && out_ready && out_end and wraps modulo 2^LEN_WIDTH.
- busy = (state==STREAM) || out_valid.
- Simultaneous events: cfg_valid during STREAM is ignored (cfg_ready=0) and must be held by its source.

Test Plan:
- Reset, then cfg_len=4 with elements 0x3F800000, 0x40000000, 0x40400000, 0x40800000 and out_ready=1 -> four beats out, each 1 cycle after input; out_end=1 only on 0x40800000; vec_count=1; busy low 1 cycle after last beat.
- cfg_len=1, one element 0x41200000 -> a single beat with out_end=1; cfg_ready high again the next cycle.
- cfg_len=0 -> cfg_err high for exactly 1 cycle, no output beats, state remains IDLE, vec_count unchanged.
- cfg_len=8, in_valid=1 continuously, out_ready toggled 1,0,0,1,... -> no element lost or duplicated; out_data stable while stalled; in_ready low exactly when out_valid && !out_ready; out_end on the 8th beat.
- Assert rst after 3 of 6 elements -> next cycle out_valid=0, vec_count=0, cfg_ready=1; a new cfg_len=2 vector then frames correctly with out_end on its 2nd beat.
- LEN_WIDTH=4, run 16 vectors of length 1 -> vec_count counts 1..15, then wraps to 0.

Source files
------------

// File: rtl/fl_vframer.sv
// Frames an unframed element stream into vectors, flagging the last element of each with out_end.
// 1-cycle registered output; in_ready drops only while a held beat is stalled (no skid buffer).
module fl_vframer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_end,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [LEN_WIDTH-1:0]  vec_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_end_q, out_end_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [LEN_WIDTH-1:0]  vec_count_q, vec_count_d;

    logic cfg_fire;
    logic cfg_zero;
    logic in_fire;
    logic out_fire;
    logic last_elem;

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_len == '0);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign last_elem = (cnt_q == (len_q - LEN_WIDTH'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_fire && !cfg_zero) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_fire && last_elem) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; in_ready follows out_ready combinationally
    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            ST_IDLE:   cfg_ready = 1'b1;
            ST_STREAM: in_ready  = !out_valid_q || out_ready;
            default: begin
                cfg_ready = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
        busy = (state_q == ST_STREAM) || out_valid_q;
    end

    always_comb begin
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_end_d   = out_end_q;
        cfg_err_d   = cfg_fire && cfg_zero;
        vec_count_d = vec_count_q;

        if (cfg_fire && !cfg_zero) begin
            len_d = cfg_len;
            cnt_d = '0;
        end

        // A new beat may load in the same cycle the previous one drains
        if (in_fire) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            out_end_d   = last_elem;
            cnt_d       = cnt_q + LEN_WIDTH'(1);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_end_d   = 1'b0;
        end

        if (out_fire && out_end_q) begin
            vec_count_d = vec_count_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_end_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            vec_count_q <= '0;
        end else begin
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_end_q   <= out_end_d;
            cfg_err_q   <= cfg_err_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_end   = out_end_q;
    assign cfg_err   = cfg_err_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_fl_vframer.sv
// Directed and randomized checks of fl_vframer against a counting-based framing model.
module tb_fl_vframer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] cfg_len;
    logic        cfg_valid, cfg_ready;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_end;
    logic        busy, cfg_err;
    logic [15:0] vec_count;

    logic [3:0]  cfg_len4;
    logic        cfg_valid4, cfg_ready4;
    logic [31:0] in_data4;
    logic        in_valid4, in_ready4;
    logic [31:0] out_data4;
    logic        out_valid4, out_ready4, out_end4;
    logic        busy4, cfg_err4;
    logic [3:0]  vec_count4;

    fl_vframer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_len(cfg_len), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_end(out_end), .busy(busy), .cfg_err(cfg_err), .vec_count(vec_count)
    );

    fl_vframer #(.DATA_WIDTH(32), .LEN_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .cfg_len(cfg_len4), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_end(out_end4), .busy(busy4), .cfg_err(cfg_err4), .vec_count(vec_count4)
    );

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic [31:0] data_src[$];
    bit          stream_m = 1'b0;
    int          cur_len = 0;
    int          sent = 0;
    logic [15:0] exp_vec = '0;
    bit          ihs_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check/model the pre-edge handshakes, then check the registered result
    task automatic tick();
        logic        pv, pr, pe, ihs, ohs, exp_rdy, err_n, l_end;
        logic [31:0] pd, l_in;
        logic [32:0] e;
        #1;
        ihs = 1'b0; ohs = 1'b0; err_n = 1'b0; l_end = 1'b0; l_in = '0;
        pv = out_valid; pr = out_ready; pd = out_data; pe = out_end;
        if (!rst) begin
            exp_rdy = stream_m && (!out_valid || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("cfg_ready", cfg_ready, !stream_m);
            chk("busy", busy, stream_m || out_valid);
            ohs = out_valid && out_ready;
            if (ohs) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[31:0]);
                    chk("out_end", out_end, e[32]);
                    if (e[32]) exp_vec++;
                end
            end
            ihs = in_valid && exp_rdy;
            if (ihs) begin
                sent++;
                l_end = (sent == cur_len);
                l_in  = in_data;
                exp_q.push_back({l_end, in_data});
                if (l_end) stream_m = 1'b0;
            end else if (cfg_valid && !stream_m) begin
                if (cfg_len == 16'd0) begin
                    err_n = 1'b1;
                end else begin
                    stream_m = 1'b1;
                    cur_len  = int'(cfg_len);
                    sent     = 0;
                end
            end
        end
        ihs_last = ihs;
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            stream_m = 1'b0;
            exp_vec  = '0;
            sent     = 0;
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_end", out_end, 0);
            chk("rst_err", cfg_err, 0);
            chk("rst_vec", vec_count, 0);
            chk("rst_cfg_ready", cfg_ready, 1);
        end else begin
            if (ihs) begin
                chk("lat_valid", out_valid, 1);
                chk("lat_data", out_data, l_in);
                chk("lat_end", out_end, l_end);
            end else if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_end", out_end, pe);
            end else begin
                chk("drain_valid", out_valid, 0);
                chk("drain_end", out_end, 0);
            end
            chk("cfg_err", cfg_err, err_n);
            chk("vec_count", vec_count, exp_vec);
        end
    endtask

    // mode 0: ready=1, valid continuous; 1: ready 1,0,0 pattern; 2: random valid/ready
    task automatic send_vec(input int len, input int mode, input int abort_after);
        int          n, cyc, guard;
        logic [31:0] d;
        cfg_len   = 16'(len);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n = 0; cyc = 0; guard = 0;
        d = (data_src.size() != 0) ? data_src.pop_front() : $urandom;
        while (n < len && guard < 2000) begin
            in_data = d;
            if (!in_valid) in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 1) == 1);
            tick();
            if (ihs_last) begin
                n++;
                d = (data_src.size() != 0) ? data_src.pop_front() : $urandom;
                if (mode == 2) in_valid = 1'b0;
            end
            cyc++; guard++;
            if (abort_after != 0 && n == abort_after) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        if (guard >= 2000) chk("stream_timeout", 0, 1);
        guard = 0;
        while (out_valid && guard < 100) begin
            out_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
            tick();
            guard++;
        end
        if (guard >= 100) chk("drain_timeout", 0, 1);
        chk("no_lost_beats", 64'(exp_q.size()), 0);
    endtask

    initial begin
        logic [31:0] d4;
        logic [3:0]  e4;
        rst = 1'b1;
        cfg_len = '0; cfg_valid = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_len4 = '0; cfg_valid4 = 1'b0; in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        data_src = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        send_vec(4, 0, 0);
        chk("vec_after_first", vec_count, 1);
        chk("busy_after_first", busy, 0);

        data_src = '{32'h41200000};
        send_vec(1, 0, 0);
        chk("vec_after_single", vec_count, 2);

        cfg_len = 16'd0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("zero_len_no_beat", out_valid, 0);
        chk("zero_len_vec", vec_count, 2);

        send_vec(8, 1, 0);
        chk("vec_after_stall", vec_count, 3);

        send_vec(6, 0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_vec", vec_count, 0);
        send_vec(2, 0, 0);
        chk("vec_after_rst", vec_count, 1);

        for (int i = 0; i < 12; i++) begin
            send_vec($urandom_range(1, 12), 2, 0);
        end
        chk("vec_after_random", vec_count, 13);

        e4 = '0;
        for (int i = 0; i < 16; i++) begin
            cfg_len4 = 4'd1; cfg_valid4 = 1'b1;
            tick();
            cfg_valid4 = 1'b0;
            in_valid4 = 1'b1;
            in_data4 = $urandom;
            d4 = in_data4;
            #1;
            chk("w4_in_ready", in_ready4, 1);
            tick();
            in_valid4 = 1'b0;
            chk("w4_valid", out_valid4, 1);
            chk("w4_end", out_end4, 1);
            chk("w4_data", out_data4, d4);
            tick();
            e4 = e4 + 4'd1;
            chk("w4_vec_count", vec_count4, e4);
            chk("w4_busy", busy4, 0);
        end
        chk("w4_wrapped", vec_count4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
